mmu_ctrl_regs: RTL and testbench

Parametrised next-generation MMU control register file: root pointers, TC, MMUSR and NUM_TT transparent-translation registers, accessed over a word-addressed register bus.
- Root pointers are 64-bit, split into two words, and commit atomically.
- Hardware fault events set MMUSR bits sticky; software clears them write-1-to-clear.
- Any TC write or root-pointer commit raises a flush handshake to the ATC, with coalescing of back-to-back requests.

---
 rtl/mmu_ctrl_regs.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mmu_ctrl_regs.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// mmu_ctrl_regs
//
// MMU control register file: CRP/SRP root pointers (64-bit, committed
// atomically on the LO write), TC, MMUSR (sticky hardware set, W1C software
// clear), NUM_TT transparent-translation registers and a CMD register.
// Any TC write, root-pointer commit or CMD bit-0 write requests an ATC flush.
// Requests that arrive while one is already outstanding coalesce into a
// single re-request.
//
// Optional feature macro: MMU_TT_LOCK_EN
//   defined   : TTi bit 15 locks TTi against further writes until rst.
//   undefined : TT writes always apply, bit 15 is plain storage.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, rd_en      register bus write / read strobes
//   addr, wr_data     word address, write data
//   rd_data, rd_valid registered read data and valid (1-cycle latency)
//   bus_err           pulses the cycle after an unmapped access
//   crp_limit/root    committed CRP upper word / root address
//   srp_limit/root    committed SRP upper word / root address
//   tc, mmu_enable    translation control, tc[31]
//   tt                TT registers, TTi at [32i+31:32i]
//   mmusr             status register
//   fault_valid/bits  hardware status set event
//   flush_req/ack     ATC flush handshake
// -----------------------------------------------------------------------------
module mmu_ctrl_regs #(
  parameter int PA_WIDTH   = 32,
  parameter int NUM_TT     = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  bus_err,
  output logic [31:0]           crp_limit,
  output logic [PA_WIDTH-1:0]   crp_root,
  output logic [31:0]           srp_limit,
  output logic [PA_WIDTH-1:0]   srp_root,
  output logic [31:0]           tc,
  output logic                  mmu_enable,
  output logic [NUM_TT*32-1:0]  tt,
  output logic [15:0]           mmusr,
  input  logic                  fault_valid,
  input  logic [15:0]           fault_bits,
  output logic                  flush_req,
  input  logic                  flush_ack
);

  localparam logic [31:0] A_CRP_HI  = 32'h00;
  localparam logic [31:0] A_CRP_LO  = 32'h01;
  localparam logic [31:0] A_SRP_HI  = 32'h02;
  localparam logic [31:0] A_SRP_LO  = 32'h03;
  localparam logic [31:0] A_TC      = 32'h04;
  localparam logic [31:0] A_MMUSR   = 32'h05;
  localparam logic [31:0] A_CMD     = 32'h06;
  localparam int          A_TT_BASE = 8;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_REQ,
    FL_REARM
  } flush_state_e;

  // Register state
  logic [31:0]         crp_hi_q, crp_hi_d, crp_sh_q, crp_sh_d;
  logic [PA_WIDTH-1:0] crp_lo_q, crp_lo_d;
  logic [31:0]         srp_hi_q, srp_hi_d, srp_sh_q, srp_sh_d;
  logic [PA_WIDTH-1:0] srp_lo_q, srp_lo_d;
  logic [31:0]         tc_q, tc_d;
  logic [15:0]         mmusr_q, mmusr_d;
  logic [31:0]         tt_q [NUM_TT];
  logic [31:0]         tt_d [NUM_TT];
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, bus_err_q, bus_err_d;
  flush_state_e        state_q, state_d;
  logic                pending_q, pending_d;

  // Decode
  logic [31:0]       addr_ext;
  logic              sel_crp_hi, sel_crp_lo, sel_srp_hi, sel_srp_lo;
  logic              sel_tc, sel_mmusr, sel_cmd, mapped;
  logic [NUM_TT-1:0] tt_sel, tt_locked;
  logic [31:0]       crp_lo_ext, srp_lo_ext, rd_word;
  logic [15:0]       mmusr_clr, mmusr_set;
  logic              trigger;

  assign addr_ext   = 32'(addr);
  assign sel_crp_hi = (addr_ext == A_CRP_HI);
  assign sel_crp_lo = (addr_ext == A_CRP_LO);
  assign sel_srp_hi = (addr_ext == A_SRP_HI);
  assign sel_srp_lo = (addr_ext == A_SRP_LO);
  assign sel_tc     = (addr_ext == A_TC);
  assign sel_mmusr  = (addr_ext == A_MMUSR);
  assign sel_cmd    = (addr_ext == A_CMD);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    tt_sel    = '0;
    tt_locked = '0;
    for (int i = 0; i < NUM_TT; i++) begin
      tt_sel[i] = (addr_ext == 32'(A_TT_BASE + i));
`ifdef MMU_TT_LOCK_EN
      tt_locked[i] = tt_q[i][15];
`endif
    end
  end

  assign mapped = sel_crp_hi | sel_crp_lo | sel_srp_hi | sel_srp_lo |
                  sel_tc | sel_mmusr | sel_cmd | (|tt_sel);

  // Flush is requested by anything that can change the translation tables'
  // interpretation, plus an explicit CMD request.
  assign trigger = wr_en & (sel_tc | sel_crp_lo | sel_srp_lo |
                            (sel_cmd & wr_data[0]));

  // Read mux: HI words return the committed value, never the shadow.
  // CMD and unmapped addresses read as zero.
  always_comb begin
    crp_lo_ext                = '0;
    crp_lo_ext[PA_WIDTH-1:0]  = crp_lo_q;
    srp_lo_ext                = '0;
    srp_lo_ext[PA_WIDTH-1:0]  = srp_lo_q;
    rd_word                   = '0;
    if (sel_crp_hi) rd_word = crp_hi_q;
    if (sel_crp_lo) rd_word = crp_lo_ext;
    if (sel_srp_hi) rd_word = srp_hi_q;
    if (sel_srp_lo) rd_word = srp_lo_ext;
    if (sel_tc)     rd_word = tc_q;
    if (sel_mmusr)  rd_word = {16'h0000, mmusr_q};
    for (int i = 0; i < NUM_TT; i++) begin
      if (tt_sel[i]) rd_word = tt_q[i];
    end
  end

  // Register next state
  always_comb begin
    crp_hi_d = crp_hi_q;
    crp_sh_d = crp_sh_q;
    crp_lo_d = crp_lo_q;
    srp_hi_d = srp_hi_q;
    srp_sh_d = srp_sh_q;
    srp_lo_d = srp_lo_q;
    tc_d     = tc_q;
    tt_d     = tt_q;
    if (wr_en) begin
      // HI writes only load the shadow; the LO write commits both halves.
      if (sel_crp_hi) crp_sh_d = wr_data;
      if (sel_crp_lo) begin
        crp_hi_d = crp_sh_q;
        crp_lo_d = wr_data[PA_WIDTH-1:0];
      end
      if (sel_srp_hi) srp_sh_d = wr_data;
      if (sel_srp_lo) begin
        srp_hi_d = srp_sh_q;
        srp_lo_d = wr_data[PA_WIDTH-1:0];
      end
      if (sel_tc) tc_d = wr_data;
      for (int i = 0; i < NUM_TT; i++) begin
        if (tt_sel[i] && !tt_locked[i]) tt_d[i] = wr_data;
      end
    end

    // Set is applied after clear so a simultaneous hardware set wins.
    mmusr_clr = (wr_en && sel_mmusr) ? wr_data[15:0] : 16'h0000;
    mmusr_set = fault_valid ? fault_bits : 16'h0000;
    mmusr_d   = (mmusr_q & ~mmusr_clr) | mmusr_set;

    // Read captures the pre-write state; rd_data holds when idle.
    rd_data_d = rd_en ? rd_word : rd_data_q;
    bus_err_d = (rd_en | wr_en) & ~mapped;
  end

  // Flush FSM next state
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      FL_IDLE: begin
        if (trigger) state_d = FL_REQ;
      end
      FL_REQ: begin
        // Triggers during an outstanding request, including one coincident
        // with the ack, coalesce into a single re-request.
        pending_d = pending_q | trigger;
        if (flush_ack) state_d = (pending_q | trigger) ? FL_REARM : FL_IDLE;
      end
      FL_REARM: begin
        pending_d = 1'b0;
        state_d   = FL_REQ;
      end
      default: begin
        pending_d = 1'b0;
        state_d   = FL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crp_hi_q   <= '0;
      crp_sh_q   <= '0;
      crp_lo_q   <= '0;
      srp_hi_q   <= '0;
      srp_sh_q   <= '0;
      srp_lo_q   <= '0;
      tc_q       <= '0;
      mmusr_q    <= '0;
      // NOTE: the TT array is a handful of flops, not a RAM, so it is reset
      // like any other register and reads back 0 after rst.
      for (int i = 0; i < NUM_TT; i++) tt_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      state_q    <= FL_IDLE;
      pending_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      crp_hi_q   <= crp_hi_d;
      crp_sh_q   <= crp_sh_d;
      crp_lo_q   <= crp_lo_d;
      srp_hi_q   <= srp_hi_d;
      srp_sh_q   <= srp_sh_d;
      srp_lo_q   <= srp_lo_d;
      tc_q       <= tc_d;
      mmusr_q    <= mmusr_d;
      for (int i = 0; i < NUM_TT; i++) tt_q[i] <= tt_d[i];
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      bus_err_q  <= bus_err_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
    end
  end

  // Outputs
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign bus_err    = bus_err_q;
  assign crp_limit  = crp_hi_q;
  assign crp_root   = crp_lo_q;
  assign srp_limit  = srp_hi_q;
  assign srp_root   = srp_lo_q;
  assign tc         = tc_q;
  assign mmu_enable = tc_q[31];
  assign mmusr      = mmusr_q;
  // Decoded straight from the state register so rst drops it asynchronously.
  assign flush_req  = (state_q == FL_REQ);

  for (genvar g = 0; g < NUM_TT; g++) begin : g_tt_out
    assign tt[32*g +: 32] = tt_q[g];
  end

endmodule

// File: tb/tb_mmu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_mmu_ctrl_regs
//
// Directed stimulus against mmu_ctrl_regs with a register-map model kept as
// an address-indexed array. The model updates on the clock edge; every
// falling edge all DUT outputs are compared against it. Directed literal
// checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_mmu_ctrl_regs;

  localparam int PA_WIDTH   = 32;
  localparam int NUM_TT     = 2;
  localparam int ADDR_WIDTH = 5;
  localparam int NREG       = 1 << ADDR_WIDTH;
  localparam logic [31:0] PA_MASK = 32'((64'd1 << PA_WIDTH) - 64'd1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  wr_en = 1'b0;
  logic                  rd_en = 1'b0;
  logic [ADDR_WIDTH-1:0] addr = '0;
  logic [31:0]           wr_data = '0;
  logic [31:0]           rd_data;
  logic                  rd_valid;
  logic                  bus_err;
  logic [31:0]           crp_limit;
  logic [PA_WIDTH-1:0]   crp_root;
  logic [31:0]           srp_limit;
  logic [PA_WIDTH-1:0]   srp_root;
  logic [31:0]           tc;
  logic                  mmu_enable;
  logic [NUM_TT*32-1:0]  tt;
  logic [15:0]           mmusr;
  logic                  fault_valid = 1'b0;
  logic [15:0]           fault_bits = '0;
  logic                  flush_req;
  logic                  flush_ack = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  mmu_ctrl_regs #(
    .PA_WIDTH   (PA_WIDTH),
    .NUM_TT     (NUM_TT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .bus_err     (bus_err),
    .crp_limit   (crp_limit),
    .crp_root    (crp_root),
    .srp_limit   (srp_limit),
    .srp_root    (srp_root),
    .tc          (tc),
    .mmu_enable  (mmu_enable),
    .tt          (tt),
    .mmusr       (mmusr),
    .fault_valid (fault_valid),
    .fault_bits  (fault_bits),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: readable register values by word address, plus root-pointer
  // shadows and the flush obligation (outstanding request, one owed
  // re-request, one-cycle gap before re-raising).
  // ---------------------------------------------------------------------------
  logic [31:0] m_reg [NREG];
  logic [31:0] m_crp_sh = '0, m_srp_sh = '0;
  logic [31:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0, m_bus_err = 1'b0;
  logic        m_req = 1'b0, m_owed = 1'b0, m_gap = 1'b0;

  int          ma;
  logic        m_mapped, m_trig;
  logic [31:0] m_rv;
  logic [15:0] m_clr, m_set;

  initial for (int i = 0; i < NREG; i++) m_reg[i] = '0;

  always_comb begin
    ma       = int'(addr);
    m_mapped = (ma <= 6) || (ma >= 8 && ma < 8 + NUM_TT);
    m_rv     = m_mapped ? m_reg[ma] : 32'h0;
    m_trig   = wr_en && m_mapped &&
               (ma == 1 || ma == 3 || ma == 4 || (ma == 6 && wr_data[0]));
    m_clr    = (wr_en && ma == 5) ? wr_data[15:0] : 16'h0;
    m_set    = fault_valid ? fault_bits : 16'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_reg[i] <= '0;
      m_crp_sh   <= '0;
      m_srp_sh   <= '0;
      m_rd_data  <= '0;
      m_rd_valid <= 1'b0;
      m_bus_err  <= 1'b0;
      m_req      <= 1'b0;
      m_owed     <= 1'b0;
      m_gap      <= 1'b0;
    end else begin
      if (rd_en) m_rd_data <= m_rv;
      m_rd_valid <= rd_en;
      m_bus_err  <= (rd_en || wr_en) && !m_mapped;
      if (wr_en && m_mapped) begin
        case (ma)
          0: m_crp_sh <= wr_data;
          1: begin m_reg[0] <= m_crp_sh; m_reg[1] <= wr_data & PA_MASK; end
          2: m_srp_sh <= wr_data;
          3: begin m_reg[2] <= m_srp_sh; m_reg[3] <= wr_data & PA_MASK; end
          4: m_reg[4] <= wr_data;
          5, 6: ;
          default: begin
`ifdef MMU_TT_LOCK_EN
            if (!m_reg[ma][15]) m_reg[ma] <= wr_data;
`else
            m_reg[ma] <= wr_data;
`endif
          end
        endcase
      end
      m_reg[5] <= {16'h0, (m_reg[5][15:0] & ~m_clr) | m_set};
      if (m_gap) begin
        m_gap  <= 1'b0;
        m_req  <= 1'b1;
        m_owed <= 1'b0;
      end else if (m_req) begin
        if (flush_ack) begin
          m_req  <= 1'b0;
          m_gap  <= m_owed || m_trig;
          m_owed <= 1'b0;
        end else if (m_trig) begin
          m_owed <= 1'b1;
        end
      end else if (m_trig) begin
        m_req <= 1'b1;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin : cmp_p
    logic [NUM_TT*32-1:0] exp_tt;
    exp_tt = '0;
    for (int i = 0; i < NUM_TT; i++) exp_tt[32*i +: 32] = m_reg[8+i];
    check("rd_data",    rd_data,    m_rd_data);
    check("rd_valid",   rd_valid,   m_rd_valid);
    check("bus_err",    bus_err,    m_bus_err);
    check("crp_limit",  crp_limit,  m_reg[0]);
    check("crp_root",   crp_root,   m_reg[1]);
    check("srp_limit",  srp_limit,  m_reg[2]);
    check("srp_root",   srp_root,   m_reg[3]);
    check("tc",         tc,         m_reg[4]);
    check("mmu_enable", mmu_enable, m_reg[4][31]);
    check("mmusr",      mmusr,      m_reg[5][15:0]);
    check("tt",         tt,         exp_tt);
    check("flush_req",  flush_req,  m_req);
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; addr = ADDR_WIDTH'(a); wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; addr = ADDR_WIDTH'(a);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic ack();
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Mid-cycle reset clears everything without a clock edge.
    wr(4, 32'h0000_0001);
    check("pre_rst_flush_req", flush_req, 1);
    check("pre_rst_tc", tc, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_flush_req", flush_req, 0);
    check("rst_tc", tc, 0);
    check("rst_mmusr", mmusr, 0);
    cycle();
    rst = 1'b0;
    rd(4);
    check("rst_rd_tc", rd_data, 0);
    check("rst_rd_valid", rd_valid, 1);

    // Atomic CRP update.
    wr(0, 32'h8000_0002);
    check("crp_hi_shadow_only", crp_limit, 0);
    rd(0);
    check("crp_hi_read_committed", rd_data, 0);
    wr(1, 32'h1234_5670);
    check("crp_limit_commit", crp_limit, 32'h8000_0002);
    check("crp_root_commit", crp_root, 32'h1234_5670);
    check("crp_flush_req", flush_req, 1);
    rd(1);
    check("crp_lo_read", rd_data, 32'h1234_5670);
    ack();
    check("crp_flush_done", flush_req, 0);

    // MMUSR W1C and set priority.
    fault_valid = 1'b1; fault_bits = 16'h00FF;
    cycle();
    fault_valid = 1'b0; fault_bits = 16'h0;
    check("mmusr_set", mmusr, 16'h00FF);
    wr(5, 32'h0);
    check("mmusr_w0", mmusr, 16'h00FF);
    wr(5, 32'h0000_000F);
    check("mmusr_w1c", mmusr, 16'h00F0);
    fault_valid = 1'b1; fault_bits = 16'h0010;
    wr(5, 32'h0000_0010);
    fault_valid = 1'b0; fault_bits = 16'h0;
    check("mmusr_set_wins", mmusr, 16'h00F0);
    rd(5);
    check("mmusr_read", rd_data, 32'h0000_00F0);

    // SRP commit, then ack outside REQ is ignored.
    wr(2, 32'h0000_0007);
    wr(3, 32'hCAFE_0000);
    check("srp_limit", srp_limit, 32'h7);
    check("srp_root", srp_root, 32'hCAFE_0000);
    ack();
    ack();
    check("idle_ack_ignored", flush_req, 0);

    // Flush coalescing.
    wr(4, 32'h8000_0000);
    check("mmu_enable", mmu_enable, 1);
    check("coal_req", flush_req, 1);
    wr(6, 32'h1);
    wr(6, 32'h1);
    check("cmd_no_change_tc", tc, 32'h8000_0000);
    ack();
    check("coal_rearm_low", flush_req, 0);
    cycle();
    check("coal_rereq", flush_req, 1);
    ack();
    check("coal_idle", flush_req, 0);
    repeat (3) cycle();
    check("coal_no_more", flush_req, 0);

    // Trigger coincident with ack sets pending.
    wr(6, 32'h1);
    flush_ack = 1'b1; wr(6, 32'h1); flush_ack = 1'b0;
    check("coinc_rearm_low", flush_req, 0);
    cycle();
    check("coinc_rereq", flush_req, 1);
    ack();
    rd(6);
    check("cmd_reads_zero", rd_data, 0);

    // Simultaneous read and write returns the pre-write value.
    rd_en = 1'b1; wr_en = 1'b1; addr = 5'h04; wr_data = 32'h0000_0012;
    cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdwr_old_value", rd_data, 32'h8000_0000);
    check("rdwr_new_tc", tc, 32'h0000_0012);
    ack();

    // Unmapped address.
    rd(4);
    rd(10);
    check("unmapped_rd_data", rd_data, 0);
    check("unmapped_rd_berr", bus_err, 1);
    wr(9, 32'h5555_AAAA);
    wr(10, 32'hDEAD_BEEF);
    check("unmapped_wr_berr", bus_err, 1);
    check("unmapped_wr_tt", tt, {32'h5555_AAAA, 32'h0});
    rd(7);
    check("unmapped7_berr", bus_err, 1);

    // TT lock.
    wr(8, 32'h0000_8001);
    wr(8, 32'h0000_0000);
    rd(8);
    check("tt_lock_berr", bus_err, 0);
`ifdef MMU_TT_LOCK_EN
    check("tt0_locked", rd_data, 32'h0000_8001);
`else
    check("tt0_unlocked", rd_data, 32'h0000_0000);
`endif

    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
